// File: rtl/gb_issue_arbiter.sv
// gb_issue_arbiter: round-robin issue controller sharing the gbprocessor ALU port between two requesters
module gb_issue_arbiter #(
    parameter int ISSUE_GAP = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [7:0]       req0_instruction,
    input  logic [7:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_instruction,
    input  logic [7:0]       req1_data,
    output logic             req1_ready,
    input  logic             hold,
    input  logic             clear_counts,
    output logic [7:0]       instruction,
    output logic [7:0]       data,
    output logic             valid,
    output logic             grant_id,
    output logic [CNT_W-1:0] cnt_arith,
    output logic [CNT_W-1:0] cnt_logic,
    output logic [CNT_W-1:0] cnt_req0,
    output logic [CNT_W-1:0] cnt_req1
);
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    localparam logic [3:0] GAP_LD = 4'(ISSUE_GAP);
    state_t state, state_n;
    logic [3:0] gap_cnt;
    logic last_grant, accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // state register; async reset drops valid immediately via state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next state: grant in IDLE, one ISSUE cycle, then ISSUE_GAP idle cycles
    always_comb begin
        state_n = state == IDLE  ? (accept ? ISSUE : IDLE) :
                  state == ISSUE ? (ISSUE_GAP > 0 ? GAP : IDLE) :
                  (gap_cnt <= 4'd1 ? IDLE : GAP);
    end

    // outputs: ready only in IDLE without hold, contention goes to the requester not last granted
    always_comb begin
        req0_ready = state == IDLE && !hold && req0_valid && (!req1_valid || last_grant);
        req1_ready = state == IDLE && !hold && req1_valid && (!req0_valid || !last_grant);
        accept     = req0_ready | req1_ready;
        valid      = state == ISSUE;
    end

    // capture the winner on the handshake edge and run the gap down-counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction <= 8'h00;
            data        <= 8'h00;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            gap_cnt     <= 4'd0;
        end else begin
            if (accept) begin
                instruction <= req1_ready ? req1_instruction : req0_instruction;
                data        <= req1_ready ? req1_data : req0_data;
                grant_id    <= req1_ready;
                last_grant  <= req1_ready;
            end
            if (state == ISSUE)     gap_cnt <= GAP_LD;
            else if (state == GAP)  gap_cnt <= gap_cnt - 4'd1;
        end
    end

    // saturating issue counters; clear overrides a coincident increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset || clear_counts) begin
            cnt_arith <= '0;
            cnt_logic <= '0;
            cnt_req0  <= '0;
            cnt_req1  <= '0;
        end else if (state == ISSUE) begin
            cnt_arith <= instruction[5] ? cnt_arith : sat_inc(cnt_arith);
            cnt_logic <= instruction[5] ? sat_inc(cnt_logic) : cnt_logic;
            cnt_req0  <= grant_id ? cnt_req0 : sat_inc(cnt_req0);
            cnt_req1  <= grant_id ? sat_inc(cnt_req1) : cnt_req1;
        end
    end
endmodule

// File: tb/tb_gb_issue_arbiter.sv
// tb_gb_issue_arbiter: directed checks of arbitration, gap timing, hold, saturation and async reset
module tb_gb_issue_arbiter;
    logic clock = 1'b0, reset = 1'b1;
    logic r0v = 0, r1v = 0, hold = 0, clr = 0;
    logic [7:0] r0i = 0, r0d = 0, r1i = 0, r1d = 0;
    logic r0_ready, r1_ready, valid, grant_id;
    logic [7:0] instruction, data;
    logic [7:0] cnt_arith, cnt_logic, cnt_req0, cnt_req1;
    logic z1v = 0;
    logic [7:0] z1i = 0, z1d = 0;
    logic z0_ready, z1_ready, zvalid, zgrant;
    logic [7:0] zinstr, zdata;
    logic [15:0] z_arith, z_logic, z_req0, z_req1;
    int n_cmp = 0, n_err = 0;

    always #5 clock = ~clock;

    gb_issue_arbiter #(.ISSUE_GAP(1), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(r0v), .req0_instruction(r0i), .req0_data(r0d), .req0_ready(r0_ready),
        .req1_valid(r1v), .req1_instruction(r1i), .req1_data(r1d), .req1_ready(r1_ready),
        .hold(hold), .clear_counts(clr),
        .instruction(instruction), .data(data), .valid(valid), .grant_id(grant_id),
        .cnt_arith(cnt_arith), .cnt_logic(cnt_logic), .cnt_req0(cnt_req0), .cnt_req1(cnt_req1)
    );

    gb_issue_arbiter #(.ISSUE_GAP(0), .CNT_W(16)) dut0 (
        .clock(clock), .reset(reset),
        .req0_valid(1'b0), .req0_instruction(8'h00), .req0_data(8'h00), .req0_ready(z0_ready),
        .req1_valid(z1v), .req1_instruction(z1i), .req1_data(z1d), .req1_ready(z1_ready),
        .hold(1'b0), .clear_counts(1'b0),
        .instruction(zinstr), .data(zdata), .valid(zvalid), .grant_id(zgrant),
        .cnt_arith(z_arith), .cnt_logic(z_logic), .cnt_req0(z_req0), .cnt_req1(z_req1)
    );

    task automatic do_reset;
        @(negedge clock);
        reset = 1; r0v = 0; r1v = 0; hold = 0; clr = 0; z1v = 0;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset = 1; r0v = 0; r1v = 0; hold = 0; clr = 0; z1v = 0;
        #1;
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", valid); end
        n_cmp++; if (instruction !== 8'h00) begin n_err++; $display("FAIL rst_instr: got %h expected 00", instruction); end
        n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h expected 00", data); end
        n_cmp++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL rst_grant: got %b expected 0", grant_id); end
        n_cmp++; if ({r0_ready, r1_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b expected 00", {r0_ready, r1_ready}); end
        n_cmp++; if ({cnt_arith, cnt_logic, cnt_req0, cnt_req1} !== 32'h0) begin n_err++; $display("FAIL rst_cnt: got %h expected 0", {cnt_arith, cnt_logic, cnt_req0, cnt_req1}); end
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_single;
        @(negedge clock);
        r0v = 1; r0i = 8'hA8; r0d = 8'h55;
        #1;
        n_cmp++; if (r0_ready !== 1'b1) begin n_err++; $display("FAIL single_r0_ready: got %b expected 1", r0_ready); end
        n_cmp++; if (r1_ready !== 1'b0) begin n_err++; $display("FAIL single_r1_ready: got %b expected 0", r1_ready); end
        @(negedge clock);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", valid); end
        n_cmp++; if (instruction !== 8'hA8) begin n_err++; $display("FAIL single_instr: got %h expected a8", instruction); end
        n_cmp++; if (data !== 8'h55) begin n_err++; $display("FAIL single_data: got %h expected 55", data); end
        n_cmp++; if (r0_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_issue: got %b expected 0", r0_ready); end
        r0v = 0;
        @(negedge clock);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_gap_valid: got %b expected 0", valid); end
        n_cmp++; if (cnt_logic !== 8'd1) begin n_err++; $display("FAIL single_cnt_logic: got %0d expected 1", cnt_logic); end
        n_cmp++; if (cnt_req0 !== 8'd1) begin n_err++; $display("FAIL single_cnt_req0: got %0d expected 1", cnt_req0); end
        n_cmp++; if (cnt_arith !== 8'd0) begin n_err++; $display("FAIL single_cnt_arith: got %0d expected 0", cnt_arith); end
        @(negedge clock);
    endtask

    task automatic test_alternate;
        int k = 0;
        do_reset();
        @(negedge clock);
        r0v = 1; r0i = 8'h98; r0d = 8'h01; r1v = 1; r1i = 8'hAB; r1d = 8'h02;
        #1;
        n_cmp++; if ({r0_ready, r1_ready} !== 2'b10) begin n_err++; $display("FAIL alt_first_ready: got %b expected 10", {r0_ready, r1_ready}); end
        for (int j = 1; j <= 12; j++) begin
            @(negedge clock);
            if (j % 3 == 1) begin
                n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL alt_valid%0d: got %b expected 1", j, valid); end
                n_cmp++; if (instruction !== (k % 2 == 1 ? 8'hAB : 8'h98)) begin n_err++; $display("FAIL alt_instr%0d: got %h expected %h", j, instruction, (k % 2 == 1 ? 8'hAB : 8'h98)); end
                n_cmp++; if (grant_id !== 1'(k % 2)) begin n_err++; $display("FAIL alt_grant%0d: got %b expected %0d", j, grant_id, k % 2); end
                k++;
            end else begin
                n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL alt_idle%0d: got %b expected 0", j, valid); end
            end
        end
        r0v = 0; r1v = 0;
        n_cmp++; if ({cnt_arith, cnt_logic, cnt_req0, cnt_req1} !== 32'h02020202) begin n_err++; $display("FAIL alt_counts: got %h expected 02020202", {cnt_arith, cnt_logic, cnt_req0, cnt_req1}); end
    endtask

    task automatic test_hold;
        @(negedge clock);
        hold = 1; r0v = 1; r1v = 1;
        for (int j = 0; j < 10; j++) begin
            #1;
            n_cmp++; if ({r0_ready, r1_ready, valid} !== 3'b000) begin n_err++; $display("FAIL hold_blocked%0d: got %b expected 000", j, {r0_ready, r1_ready, valid}); end
            @(negedge clock);
        end
        hold = 0;
        #1;
        n_cmp++; if ({r0_ready, r1_ready} !== 2'b10) begin n_err++; $display("FAIL hold_release_ready: got %b expected 10", {r0_ready, r1_ready}); end
        @(negedge clock);
        n_cmp++; if ({valid, instruction} !== {1'b1, 8'h98}) begin n_err++; $display("FAIL hold_release_issue: got %b/%h expected 1/98", valid, instruction); end
        r0v = 0; r1v = 0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_saturate;
        int issues = 0, cyc = 0;
        do_reset();
        @(negedge clock);
        r0v = 1;
        while (issues < 1000 && cyc < 4000) begin
            r0i = 8'hB8 | 8'(cyc % 8); r0d = 8'(cyc);
            @(negedge clock);
            cyc++;
            if (valid) issues++;
        end
        n_cmp++; if (issues !== 1000) begin n_err++; $display("FAIL sat_issue_count: got %0d expected 1000", issues); end
        @(negedge clock);
        n_cmp++; if (cnt_logic !== 8'd255) begin n_err++; $display("FAIL sat_logic: got %0d expected 255", cnt_logic); end
        n_cmp++; if (cnt_req0 !== 8'd255) begin n_err++; $display("FAIL sat_req0: got %0d expected 255", cnt_req0); end
        n_cmp++; if ({cnt_arith, cnt_req1} !== 16'h0) begin n_err++; $display("FAIL sat_zero: got %h expected 0000", {cnt_arith, cnt_req1}); end
        for (int i = 0; i < 4 && !valid; i++) @(negedge clock);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL sat_find_issue: got %b expected 1", valid); end
        clr = 1;
        @(negedge clock);
        clr = 0; r0v = 0;
        n_cmp++; if ({cnt_logic, cnt_req0} !== 16'h0) begin n_err++; $display("FAIL sat_clear: got %h expected 0000", {cnt_logic, cnt_req0}); end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_async_reset;
        do_reset();
        @(negedge clock);
        r0v = 1; r0i = 8'h80; r0d = 8'h11;
        @(negedge clock);
        r0v = 0;
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid: got %b expected 1", valid); end
        #1 reset = 1;
        #1;
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ar_valid_drop: got %b expected 0", valid); end
        n_cmp++; if (instruction !== 8'h00) begin n_err++; $display("FAIL ar_instr: got %h expected 00", instruction); end
        @(negedge clock);
        reset = 0; r0v = 1; r1v = 1; r0i = 8'h88; r1i = 8'hA0;
        #1;
        n_cmp++; if ({r0_ready, r1_ready} !== 2'b10) begin n_err++; $display("FAIL ar_contention: got %b expected 10", {r0_ready, r1_ready}); end
        @(negedge clock);
        r0v = 0; r1v = 0;
        n_cmp++; if ({valid, grant_id, instruction} !== {2'b10, 8'h88}) begin n_err++; $display("FAIL ar_issue: got %b/%b/%h expected 1/0/88", valid, grant_id, instruction); end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_gap0;
        @(negedge clock);
        z1v = 1; z1i = 8'h90; z1d = 8'h33;
        #1;
        n_cmp++; if (z1_ready !== 1'b1) begin n_err++; $display("FAIL g0_first_ready: got %b expected 1", z1_ready); end
        for (int j = 1; j <= 10; j++) begin
            @(negedge clock);
            n_cmp++; if (zvalid !== 1'(j % 2)) begin n_err++; $display("FAIL g0_valid%0d: got %b expected %0d", j, zvalid, j % 2); end
            n_cmp++; if (z1_ready !== 1'(1 - j % 2)) begin n_err++; $display("FAIL g0_ready%0d: got %b expected %0d", j, z1_ready, 1 - j % 2); end
        end
        z1v = 0;
        n_cmp++; if ({z_req1, z_arith, z_logic} !== {16'd5, 16'd5, 16'd0}) begin n_err++; $display("FAIL g0_counts: got %0d/%0d/%0d expected 5/5/0", z_req1, z_arith, z_logic); end
        n_cmp++; if ({zinstr, zdata, zgrant} !== {8'h90, 8'h33, 1'b1}) begin n_err++; $display("FAIL g0_capture: got %h/%h/%b expected 90/33/1", zinstr, zdata, zgrant); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_hold();
        test_saturate();
        test_async_reset();
        test_gap0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
